// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared widths, FSM state codes and saturation limits for conv_window_mac
//
// Purpose : width helpers for the product (M_BW) and accumulator (ACC_BW) datapaths, the
//           configuration FSM state codes, and the output clamp limits.
// Ports   : none (package).
// Macro   : CONV_RELU_EN - when defined, outputs are ReLU'd and clamped unsigned;
//           when undefined, outputs are clamped signed.
package conv_pkg;

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_READY = 2'd2;

`ifdef CONV_RELU_EN
   localparam bit RELU_EN = 1'b1;
`else
   localparam bit RELU_EN = 1'b0;
`endif

   // Unsigned pixel is widened by one zero bit so it multiplies as signed.
   function automatic int m_bw_f(input int i_f_bw, input int w_bw);
      return i_f_bw + w_bw + 1;
   endfunction

   // Room for KX*KY products plus a bias, with a guard bit.
   function automatic int acc_bw_f(input int i_f_bw, input int w_bw, input int kx, input int ky);
      return m_bw_f(i_f_bw, w_bw) + $clog2(kx * ky) + 1;
   endfunction

   // With ReLU the lower clamp is 0, so ReLU followed by clamp collapses into one clamp.
   function automatic longint sat_hi(input int o_f_bw);
      return RELU_EN ? ((longint'(1) << o_f_bw) - 1) : ((longint'(1) << (o_f_bw - 1)) - 1);
   endfunction

   function automatic longint sat_lo(input int o_f_bw);
      return RELU_EN ? longint'(0) : -(longint'(1) << (o_f_bw - 1));
   endfunction

endpackage

// File: rtl/conv_kernel_tree.sv
// rtl/conv_kernel_tree.sv - one output channel's row sums, bias add and activation/clamp
//
// Purpose : stages S2..S4 of a single conv kernel. S2 registers the KY row sums and the bias,
//           S3 registers the full accumulation, S4 registers the clamped output pixel.
// Ports   : clk, reset_n (async, active-low)
//           s1_valid/s2_valid/s3_valid - stage enables from the top-level valid pipe
//           products - KX*KY signed products, element k at [k*M_BW +: M_BW]
//           bias     - channel bias latched alongside the products
//           fmap     - output pixel, holds its value while no new result arrives
// Macro   : CONV_RELU_EN selects the clamp limits (see conv_pkg).
module conv_kernel_tree
   import conv_pkg::*;
#(
   parameter int KX     = 5,
   parameter int KY     = 5,
   parameter int M_BW   = 17,
   parameter int B_BW   = 16,
   parameter int ACC_BW = 23,
   parameter int O_F_BW = 16
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     s1_valid,
   input  logic                     s2_valid,
   input  logic                     s3_valid,
   input  logic [KX*KY*M_BW-1:0]    products,
   input  logic signed [B_BW-1:0]   bias,
   output logic [O_F_BW-1:0]        fmap
);

   localparam logic signed [ACC_BW-1:0] SAT_HI = ACC_BW'(sat_hi(O_F_BW));
   localparam logic signed [ACC_BW-1:0] SAT_LO = ACC_BW'(sat_lo(O_F_BW));

   logic signed [ACC_BW-1:0] row_next [KY];
   logic signed [ACC_BW-1:0] row_sum  [KY];
   logic signed [ACC_BW-1:0] bias_s2;
   logic signed [ACC_BW-1:0] acc_next;
   logic signed [ACC_BW-1:0] acc;
   logic        [O_F_BW-1:0] fmap_next;

   always_comb begin
      for (int r = 0; r < KY; r++) begin
         row_next[r] = '0;
         for (int x = 0; x < KX; x++) begin
            row_next[r] = row_next[r] + ACC_BW'($signed(products[(r*KX+x)*M_BW +: M_BW]));
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int r = 0; r < KY; r++) row_sum[r] <= '0;
         bias_s2 <= '0;
      end else if (s1_valid) begin
         row_sum <= row_next;
         bias_s2 <= ACC_BW'(bias);
      end
   end

   always_comb begin
      acc_next = bias_s2;
      for (int r = 0; r < KY; r++) acc_next = acc_next + row_sum[r];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)      acc <= '0;
      else if (s2_valid) acc <= acc_next;
   end

   always_comb begin
      fmap_next = acc[O_F_BW-1:0];
      if (acc > SAT_HI)      fmap_next = SAT_HI[O_F_BW-1:0];
      else if (acc < SAT_LO) fmap_next = SAT_LO[O_F_BW-1:0];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)      fmap <= '0;
      else if (s3_valid) fmap <= fmap_next;
   end

endmodule

// File: rtl/conv_window_mac.sv
// rtl/conv_window_mac.sv - OCH parallel KxK conv kernels on a window stream, double-buffered weights
//
// Purpose : consumes one KX*KY window per cycle, produces one pixel per output channel with a
//           fixed latency of 4 cycles. Weights/biases load into a shadow bank through a small
//           FSM and swap into the active bank on the final word without stalling the stream.
// Ports   : clk, reset_n (async assert, released through a 2-flop synchroniser)
//           i_window_valid/i_window - window stream, element (wy,wx) at [(wy*KX+wx)*I_F_BW +: I_F_BW]
//           i_cfg_start/i_cfg_valid/i_cfg_data - bank load: per channel KY*KX weights then one bias
//           o_cfg_busy - loading; o_weights_ready - active bank complete
//           o_ot_valid/o_ot_fmap - results, channel c at [c*O_F_BW +: O_F_BW]
//           o_drop_cnt - saturating count of windows arriving with no usable bank
// Macro   : CONV_RELU_EN - ReLU + unsigned clamp when defined, signed clamp otherwise.
module conv_window_mac
   import conv_pkg::*;
#(
   parameter int I_F_BW = 8,
   parameter int W_BW   = 8,
   parameter int B_BW   = 16,
   parameter int KX     = 5,
   parameter int KY     = 5,
   parameter int OCH    = 3,
   parameter int O_F_BW = 16
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     i_window_valid,
   input  logic [KX*KY*I_F_BW-1:0]  i_window,
   input  logic                     i_cfg_start,
   input  logic                     i_cfg_valid,
   input  logic [B_BW-1:0]          i_cfg_data,
   output logic                     o_cfg_busy,
   output logic                     o_weights_ready,
   output logic                     o_ot_valid,
   output logic [OCH*O_F_BW-1:0]    o_ot_fmap,
   output logic [15:0]              o_drop_cnt
);

   localparam int KK     = KX * KY;
   localparam int M_BW   = m_bw_f(I_F_BW, W_BW);
   localparam int ACC_BW = acc_bw_f(I_F_BW, W_BW, KX, KY);
   localparam int PW     = $clog2(KK + 1);
   localparam int CW     = (OCH > 1) ? $clog2(OCH) : 1;

   // Reset: asserts immediately, releases on a clock edge.
   logic [1:0] rst_sync;
   logic       rst_n;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rst_sync <= 2'b00;
      else          rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_n = rst_sync[1];

   logic [1:0]             state;
   logic [CW-1:0]          ch_cnt;
   logic [PW-1:0]          pos_cnt;
   logic signed [W_BW-1:0] shadow_w [OCH][KK];
   logic signed [W_BW-1:0] act_w    [OCH][KK];
   logic signed [B_BW-1:0] shadow_b [OCH];
   logic signed [B_BW-1:0] act_b    [OCH];

   assign o_cfg_busy = (state == ST_LOAD);

   // Word position is tracked as (channel, slot) so no divider is needed; slot KK is the bias.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= ST_EMPTY;
         ch_cnt          <= '0;
         pos_cnt         <= '0;
         o_weights_ready <= 1'b0;
         for (int c = 0; c < OCH; c++) begin
            shadow_b[c] <= '0;
            act_b[c]    <= '0;
            for (int k = 0; k < KK; k++) begin
               shadow_w[c][k] <= '0;
               act_w[c][k]    <= '0;
            end
         end
      end else begin
         case (state)
            ST_LOAD: begin
               // A start here restarts the load and outranks a coincident final word.
               if (i_cfg_start) begin
                  ch_cnt  <= '0;
                  pos_cnt <= '0;
               end else if (i_cfg_valid) begin
                  if (pos_cnt == PW'(KK)) begin
                     shadow_b[ch_cnt] <= i_cfg_data;
                     pos_cnt          <= '0;
                     if (ch_cnt == CW'(OCH - 1)) begin
                        // Final word goes straight into the active bank along with the shadow.
                        ch_cnt          <= '0;
                        state           <= ST_READY;
                        o_weights_ready <= 1'b1;
                        act_w           <= shadow_w;
                        for (int c = 0; c < OCH; c++)
                           act_b[c] <= (c == OCH - 1) ? $signed(i_cfg_data) : shadow_b[c];
                     end else begin
                        ch_cnt <= ch_cnt + 1'b1;
                     end
                  end else begin
                     shadow_w[ch_cnt][pos_cnt] <= i_cfg_data[W_BW-1:0];
                     pos_cnt                   <= pos_cnt + 1'b1;
                  end
               end
            end
            default: begin
               if (i_cfg_start) begin
                  state   <= ST_LOAD;
                  ch_cnt  <= '0;
                  pos_cnt <= '0;
               end
            end
         endcase
      end
   end

   logic accept;
   assign accept = i_window_valid && o_weights_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                        o_drop_cnt <= '0;
      else if (i_window_valid && !o_weights_ready &&
               (o_drop_cnt != 16'hFFFF))                 o_drop_cnt <= o_drop_cnt + 16'd1;
   end

   // S1: products and bias latched from the active bank that is current in the accept cycle.
   logic                   v1, v2, v3;
   logic [KK*M_BW-1:0]     prod    [OCH];
   logic signed [B_BW-1:0] bias_s1 [OCH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1         <= 1'b0;
         v2         <= 1'b0;
         v3         <= 1'b0;
         o_ot_valid <= 1'b0;
         for (int c = 0; c < OCH; c++) begin
            prod[c]    <= '0;
            bias_s1[c] <= '0;
         end
      end else begin
         v1         <= accept;
         v2         <= v1;
         v3         <= v2;
         o_ot_valid <= v3;
         if (accept) begin
            for (int c = 0; c < OCH; c++) begin
               bias_s1[c] <= act_b[c];
               for (int k = 0; k < KK; k++) begin
                  prod[c][k*M_BW +: M_BW] <=
                     $signed({{(M_BW-I_F_BW){1'b0}}, i_window[k*I_F_BW +: I_F_BW]}) *
                     M_BW'(act_w[c][k]);
               end
            end
         end
      end
   end

   for (genvar c = 0; c < OCH; c++) begin : g_ch
      conv_kernel_tree #(
         .KX     (KX),
         .KY     (KY),
         .M_BW   (M_BW),
         .B_BW   (B_BW),
         .ACC_BW (ACC_BW),
         .O_F_BW (O_F_BW)
      ) u_tree (
         .clk      (clk),
         .reset_n  (rst_n),
         .s1_valid (v1),
         .s2_valid (v2),
         .s3_valid (v3),
         .products (prod[c]),
         .bias     (bias_s1[c]),
         .fmap     (o_ot_fmap[c*O_F_BW +: O_F_BW])
      );
   end

endmodule

// File: tb/tb_conv_window_mac.sv
// tb/tb_conv_window_mac.sv - self-checking bench for conv_window_mac
module tb_conv_window_mac;

   localparam int KK  = 25;
   localparam int OCH = 3;
   localparam int NW  = OCH * (KK + 1);
   localparam int OBW = 16;

`ifdef CONV_RELU_EN
   localparam logic [15:0] T2_C1 = 16'd0;
   localparam logic [15:0] T3_HI = 16'hFFFF;
   localparam logic [15:0] T3_LO = 16'h0000;
`else
   localparam logic [15:0] T2_C1 = 16'hFF6A;
   localparam logic [15:0] T3_HI = 16'h7FFF;
   localparam logic [15:0] T3_LO = 16'h8000;
`endif

   logic                 clk = 1'b0;
   logic                 reset_n;
   logic                 i_window_valid;
   logic [KK*8-1:0]      i_window;
   logic                 i_cfg_start;
   logic                 i_cfg_valid;
   logic [15:0]          i_cfg_data;
   logic                 o_cfg_busy;
   logic                 o_weights_ready;
   logic                 o_ot_valid;
   logic [OCH*OBW-1:0]   o_ot_fmap;
   logic [15:0]          o_drop_cnt;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   conv_window_mac dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .i_window_valid  (i_window_valid),
      .i_window        (i_window),
      .i_cfg_start     (i_cfg_start),
      .i_cfg_valid     (i_cfg_valid),
      .i_cfg_data      (i_cfg_data),
      .o_cfg_busy      (o_cfg_busy),
      .o_weights_ready (o_weights_ready),
      .o_ot_valid      (o_ot_valid),
      .o_ot_fmap       (o_ot_fmap),
      .o_drop_cnt      (o_drop_cnt)
   );

   typedef struct {
      int                 cyc;
      logic [OCH*OBW-1:0] fmap;
   } exp_t;

   exp_t sb[$];
   int   pass_cnt  = 0;
   int   fail_cnt  = 0;
   int   total_cnt = 0;
   bit   mon_en    = 0;

   int   m_sw [OCH][KK];
   int   m_sb [OCH];
   int   m_aw [OCH][KK];
   int   m_ab [OCH];
   bit   m_ready;
   bit   m_loading;
   int   m_cnt;
   int   m_drop;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] pix(input int base, input bit mode, input int k);
      return mode ? 8'((base + 37 * k) % 256) : 8'(base);
   endfunction

   function automatic logic [OCH*OBW-1:0] model_out(input int base, input bit mode);
      logic [OCH*OBW-1:0] r;
      longint acc, hi, lo;
`ifdef CONV_RELU_EN
      hi = 65535; lo = 0;
`else
      hi = 32767; lo = -32768;
`endif
      r = '0;
      for (int c = 0; c < OCH; c++) begin
         acc = m_ab[c];
         for (int k = 0; k < KK; k++) acc += longint'(pix(base, mode, k)) * m_aw[c][k];
         if (acc > hi) acc = hi;
         if (acc < lo) acc = lo;
         r[c*OBW +: OBW] = OBW'(acc);
      end
      return r;
   endfunction

   task automatic model_reset();
      m_ready = 0; m_loading = 0; m_cnt = 0; m_drop = 0;
      for (int c = 0; c < OCH; c++) begin
         m_sb[c] = 0; m_ab[c] = 0;
         for (int k = 0; k < KK; k++) begin m_sw[c][k] = 0; m_aw[c][k] = 0; end
      end
   endtask

   // One clock of stimulus; the model decides acceptance against the bank valid at this edge.
   task automatic step(input bit wv, input int base, input bit mode,
                       input bit cs, input bit cv, input logic [15:0] cd);
      exp_t e;
      int   c, p;
      @(posedge clk); #1;
      i_window_valid = wv;
      for (int k = 0; k < KK; k++) i_window[k*8 +: 8] = wv ? pix(base, mode, k) : 8'd0;
      i_cfg_start = cs;
      i_cfg_valid = cv;
      i_cfg_data  = cd;
      if (wv) begin
         if (m_ready) begin
            e.cyc  = cyc + 4;
            e.fmap = model_out(base, mode);
            sb.push_back(e);
         end else if (m_drop < 65535) begin
            m_drop++;
         end
      end
      if (m_loading) begin
         if (cs) m_cnt = 0;
         else if (cv) begin
            c = m_cnt / (KK + 1);
            p = m_cnt % (KK + 1);
            if (p == KK) m_sb[c] = int'($signed(cd));
            else         m_sw[c][p] = int'($signed(cd[7:0]));
            if (m_cnt == NW - 1) begin
               m_aw = m_sw; m_ab = m_sb;
               m_ready = 1; m_loading = 0; m_cnt = 0;
            end else m_cnt++;
         end
      end else if (cs) begin
         m_loading = 1; m_cnt = 0;
      end
   endtask

   task automatic idle(input int n, input bit wv, input int base);
      repeat (n) step(wv, base, 0, 0, 0, 16'd0);
   endtask

   task automatic load(input int w0, input int w1, input int w2,
                       input int b0, input int b1, input int b2,
                       input bit wmode, input bit win_on, input bit abort_last);
      int          c, p, w, b;
      logic [15:0] d;
      step(win_on, 10, 0, 1, 0, 16'd0);
      for (int i = 0; i < NW; i++) begin
         c = i / (KK + 1);
         p = i % (KK + 1);
         w = (c == 0) ? w0 : (c == 1) ? w1 : w2;
         b = (c == 0) ? b0 : (c == 1) ? b1 : b2;
         if (p == KK) d = 16'(b);
         else         d = 16'(w + (wmode ? p - 12 : 0));
         step(win_on, 10, 0, abort_last && (i == NW - 1), 1, d);
      end
   endtask

   always @(negedge clk) begin : mon
      bit   due;
      exp_t e;
      if (mon_en) begin
         due = (sb.size() > 0) && (sb[0].cyc == cyc);
         if (due || o_ot_valid) begin
            check("ot_valid", 64'(o_ot_valid), 64'(due));
            if (due) begin
               e = sb.pop_front();
               check("ot_fmap", 64'(o_ot_fmap), 64'(e.fmap));
            end
         end
      end
   end

   initial begin
      model_reset();
      reset_n = 1'b0;
      i_window_valid = 1'b0; i_window = '0;
      i_cfg_start = 1'b0; i_cfg_valid = 1'b0; i_cfg_data = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ot_valid", 64'(o_ot_valid), 64'd0);
      check("rst_ready", 64'(o_weights_ready), 64'd0);
      check("rst_busy", 64'(o_cfg_busy), 64'd0);
      check("rst_drop", 64'(o_drop_cnt), 64'd0);
      check("rst_fmap", 64'(o_ot_fmap), 64'd0);
      @(negedge clk) reset_n = 1'b1;
      idle(4, 0, 0);
      mon_en = 1;

      // No bank loaded: every window dropped.
      repeat (10) step(1, 10, 0, 0, 0, 16'd0);
      idle(6, 0, 0);
      check("t1_drop", 64'(o_drop_cnt), 64'd10);
      check("t1_ready", 64'(o_weights_ready), 64'd0);

      // Basic bank and single window of 10s.
      load(1, -1, 2, 0, 100, -5, 0, 0, 0);
      idle(2, 0, 0);
      check("t2_ready", 64'(o_weights_ready), 64'd1);
      check("t2_busy", 64'(o_cfg_busy), 64'd0);
      step(1, 10, 0, 0, 0, 16'd0);
      idle(6, 0, 0);
      check("t2_fmap", 64'(o_ot_fmap), 64'({16'd495, T2_C1, 16'd250}));

      // Saturation at both ends.
      load(127, -128, 3, 32767, -32768, 7, 0, 0, 0);
      idle(2, 0, 0);
      step(1, 255, 0, 0, 0, 16'd0);
      idle(6, 0, 0);
      check("t3_fmap", 64'(o_ot_fmap), 64'({16'd19132, T3_LO, T3_HI}));

      // Position-dependent weights and pixels exercise element ordering.
      load(1, -2, 0, 11, -20, 300, 1, 0, 0);
      idle(2, 0, 0);
      step(1, 3, 1, 0, 0, 16'd0);
      idle(6, 0, 0);

      // Back-to-back windows.
      for (int i = 0; i < 24; i++) step(1, i * 11, 1, 0, 0, 16'd0);
      idle(8, 0, 0);
      check("t4_drained", 64'(sb.size()), 64'd0);

      // Live reload under a continuous stream, then an aborted load, then a restarted load.
      load(1, -1, 2, 0, 100, -5, 0, 0, 0);
      idle(2, 1, 10);
      load(2, -1, 2, 0, 100, -5, 0, 1, 0);
      idle(3, 1, 10);
      check("t5_busy_done", 64'(o_cfg_busy), 64'd0);
      load(1, -1, 2, 0, 100, -5, 0, 1, 1);
      #1;
      check("t5_busy_abort", 64'(o_cfg_busy), 64'd1);
      check("t5_ready_abort", 64'(o_weights_ready), 64'd1);
      idle(4, 1, 10);
      load(1, -1, 2, 0, 100, -5, 0, 1, 0);
      idle(4, 1, 10);
      idle(6, 0, 0);
      check("t5_busy_end", 64'(o_cfg_busy), 64'd0);
      check("t5_fmap", 64'(o_ot_fmap), 64'({16'd495, T2_C1, 16'd250}));
      check("t5_drop", 64'(o_drop_cnt), 64'(m_drop));
      check("t5_drained", 64'(sb.size()), 64'd0);

      // Asynchronous reset with the pipeline full.
      repeat (6) step(1, 10, 0, 0, 0, 16'd0);
      #2;
      check("t6_pre_valid", 64'(o_ot_valid), 64'd1);
      mon_en  = 0;
      reset_n = 1'b0;
      #1;
      check("t6_valid", 64'(o_ot_valid), 64'd0);
      check("t6_ready", 64'(o_weights_ready), 64'd0);
      check("t6_drop", 64'(o_drop_cnt), 64'd0);
      check("t6_fmap", 64'(o_ot_fmap), 64'd0);
      sb.delete();
      model_reset();
      idle(2, 0, 0);
      reset_n = 1'b1;
      idle(4, 0, 0);
      mon_en = 1;
      step(1, 10, 0, 0, 0, 16'd0);
      idle(6, 0, 0);
      check("t6_post_drop", 64'(o_drop_cnt), 64'd1);
      check("t6_post_ready", 64'(o_weights_ready), 64'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
